// File: rtl/lcrc_pkg.sv
// Shared constants, FSM state encoding and the CRC fold for the LCRC transmit path.
// The fold feeds the low byte first and the LSB first within each byte into an MSB-first shift register.
package lcrc_pkg;

    localparam logic [31:0] LCRC_SEED = 32'hFFFF_FFFF;
    localparam logic [31:0] LCRC_POLY = 32'h04C1_1DB7;
    localparam int          HDR_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_CRC_HI = 2'd2,
        ST_CRC_LO = 2'd3
    } lcrc_state_t;

    function automatic logic [31:0] crc_fold16(input logic [31:0] crc, input logic [15:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 16; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? LCRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/lcrc_engine.sv
// Single-cycle 16-bit LCRC update; init restarts from the seed and can be combined with en
// so that the first word of a frame is folded in the same cycle as the restart.
module lcrc_engine
    import lcrc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [15:0] i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;
    logic [31:0] w_base;

    assign w_base = i_init ? LCRC_SEED : r_crc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_crc <= LCRC_SEED;
        end else if (i_en) begin
            r_crc <= crc_fold16(w_base, i_data);
        end else if (i_init) begin
            r_crc <= LCRC_SEED;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/lcrc_tx_sequencer.sv
// Frames upstream TLPs as header + payload + two complemented LCRC words through a single-stage output register.
//   state     | meaning
//   ST_IDLE   | waiting for an sop word; emits the header, drops stray non-sop words
//   ST_DATA   | forwarding payload words and folding them into the CRC
//   ST_CRC_HI | emitting ~crc[31:16]
//   ST_CRC_LO | emitting ~crc[15:0] with eop, then bumping the sequence number
module lcrc_tx_sequencer
    import lcrc_pkg::*;
#(
    parameter int         SEQ_W   = 12,
    parameter logic [3:0] HDR_PAD = 4'b0000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic [15:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic [SEQ_W-1:0] seq_num,
    output logic             err
);

    lcrc_state_t      r_state;
    logic [15:0]      r_out_data;
    logic             r_out_valid;
    logic             r_out_sop;
    logic             r_out_eop;
    logic [SEQ_W-1:0] r_seq;
    logic             r_err;
    logic             r_first;

    logic             w_slot_free;
    logic             w_hdr_go;
    logic             w_data_acc;
    logic             w_drop;
    logic [HDR_W-1:0] w_hdr;
    logic [31:0]      w_crc;
    logic             w_crc_init;
    logic             w_crc_en;
    logic [15:0]      w_crc_data;

    assign w_slot_free = !r_out_valid || out_ready;
    assign w_hdr       = HDR_W'({HDR_PAD, r_seq});
    assign w_hdr_go    = (r_state == ST_IDLE) && in_valid && in_sop && w_slot_free;
    assign w_data_acc  = (r_state == ST_DATA) && in_valid && w_slot_free;
    assign w_drop      = (r_state == ST_IDLE) && in_valid && !in_sop;

    // The sop word is held off in IDLE so the header can go out first; it is taken in DATA next cycle.
    assign in_ready = reset_n && (((r_state == ST_IDLE) && !in_sop) ||
                                  ((r_state == ST_DATA) && w_slot_free));

    assign w_crc_init = w_hdr_go;
    assign w_crc_en   = w_hdr_go || w_data_acc;
    assign w_crc_data = w_hdr_go ? w_hdr : in_data;

    lcrc_engine u_lcrc_engine (
        .clk     (clk),
        .reset_n (reset_n),
        .i_init  (w_crc_init),
        .i_en    (w_crc_en),
        .i_data  (w_crc_data),
        .o_crc   (w_crc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_seq       <= '0;
            r_err       <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hdr_go) begin
                        r_out_data  <= w_hdr;
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b1;
                        r_out_eop   <= 1'b0;
                        r_first     <= 1'b1;
                        r_state     <= ST_DATA;
                    end else if (w_slot_free) begin
                        r_out_valid <= 1'b0;
                        r_out_sop   <= 1'b0;
                        r_out_eop   <= 1'b0;
                    end
                    if (w_drop) begin
                        r_err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_data_acc) begin
                        r_out_data  <= in_data;
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b0;
                        r_out_eop   <= 1'b0;
                        r_first     <= 1'b0;
                        if (in_sop && !r_first) begin
                            r_err <= 1'b1;
                        end
                        if (in_eop) begin
                            r_state <= ST_CRC_HI;
                        end
                    end else if (w_slot_free) begin
                        r_out_valid <= 1'b0;
                    end
                end
                ST_CRC_HI: begin
                    if (w_slot_free) begin
                        r_out_data  <= ~w_crc[31:16];
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b0;
                        r_out_eop   <= 1'b0;
                        r_state     <= ST_CRC_LO;
                    end
                end
                ST_CRC_LO: begin
                    // Leaving as the last word enters the slot lets the next header follow with no bubble.
                    if (w_slot_free) begin
                        r_out_data  <= ~w_crc[15:0];
                        r_out_valid <= 1'b1;
                        r_out_sop   <= 1'b0;
                        r_out_eop   <= 1'b1;
                        r_seq       <= r_seq + SEQ_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign seq_num   = r_seq;
    assign err       = r_err;

endmodule

// File: tb/tb_lcrc_tx_sequencer.sv
// Directed bench for lcrc_tx_sequencer: a scoreboard queue of expected output words
// is filled by the driver and drained by a monitor on the falling edge.
module tb_lcrc_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic        in_eop;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [11:0] seq_num;
    logic        err;

    int checks   = 0;
    int failures = 0;

    logic [17:0] sb[$];
    logic [31:0] exp_crc;
    int          exp_seq;
    int          cyc = 0;
    int          pop_total = 0;
    bit          tog_en = 0;
    bit          stall_pending = 0;
    logic [18:0] held;
    bit          bb_en = 0;
    bit          bb_started = 0;
    int          bb_first, bb_last, bb_n;

    lcrc_tx_sequencer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .seq_num   (seq_num),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        if (tog_en) out_ready = ~out_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_fold(input logic [31:0] c, input logic [15:0] w);
        logic [31:0] r;
        logic [7:0]  b;
        r = c;
        for (int by = 0; by < 2; by++) begin
            b = (by == 0) ? w[7:0] : w[15:8];
            for (int k = 0; k < 8; k++) begin
                if (r[31] ^ b[0]) r = (r << 1) ^ 32'h04C1_1DB7;
                else              r = r << 1;
                b = b >> 1;
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        logic [17:0] e;
        if (reset_n) begin
            if (stall_pending)
                chk("stall_hold", {13'b0, out_valid, out_sop, out_eop, out_data}, {13'b0, held});
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_output observed=%h expected=none", out_data);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_word", {14'b0, out_sop, out_eop, out_data}, {14'b0, e});
                end
                pop_total++;
                if (bb_en) begin
                    if (!bb_started) begin bb_first = cyc; bb_started = 1; end
                    bb_last = cyc;
                    bb_n++;
                end
            end
            stall_pending = out_valid && !out_ready;
            held = {out_valid, out_sop, out_eop, out_data};
        end else begin
            stall_pending = 0;
        end
    end

    task automatic start_tlp();
        logic [15:0] hdr;
        hdr = {4'h0, 12'(exp_seq)};
        sb.push_back({2'b10, hdr});
        exp_crc = m_fold(32'hFFFF_FFFF, hdr);
    endtask

    task automatic send_word(input logic [15:0] d, input logic sop, input logic eop);
        int   g;
        logic acc;
        logic [31:0] c;
        in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
        acc = 1'b0; g = 0;
        while (!acc && g < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end
        chk("accept_timeout", {31'b0, acc}, 32'd1);
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        sb.push_back({2'b00, d});
        exp_crc = m_fold(exp_crc, d);
        if (eop) begin
            c = ~exp_crc;
            sb.push_back({2'b00, c[31:16]});
            sb.push_back({2'b01, c[15:0]});
            exp_seq = (exp_seq + 1) % 4096;
        end
    endtask

    task automatic send_tlp(input int n, input logic [15:0] base);
        start_tlp();
        for (int i = 0; i < n; i++)
            send_word(16'(base + i), i == 0, i == n - 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb.size() != 0 || out_valid) && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_sb", sb.size(), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data",  {16'b0, out_data},  32'd0);
        chk("rst_sop_eop",   {30'b0, out_sop, out_eop}, 32'd0);
        chk("rst_seq_num",   {20'b0, seq_num},   32'd0);
        chk("rst_err",       {31'b0, err},       32'd0);
        chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
        sb.delete();
        exp_seq = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        reset_n = 1'b0; in_data = '0; in_valid = 0; in_sop = 0; in_eop = 0; out_ready = 1'b1;
        exp_seq = 0;
        #2;
        do_reset();

        // Basic 2-word TLP
        start_tlp();
        send_word(16'h1234, 1'b1, 1'b0);
        send_word(16'h5678, 1'b0, 1'b1);
        drain();
        chk("seq_after_first", {20'b0, seq_num}, 32'd1);
        chk("err_clean", {31'b0, err}, 32'd0);

        // Single-word TLP produces exactly four words
        p0 = pop_total;
        send_tlp(1, 16'hA5C3);
        drain();
        chk("single_word_count", pop_total - p0, 32'd4);

        // Back-to-back TLPs with out_ready high: output words on consecutive cycles
        bb_en = 1; bb_started = 0; bb_n = 0;
        send_tlp(1, 16'h0101);
        send_tlp(2, 16'h0202);
        send_tlp(1, 16'h0303);
        drain();
        bb_en = 0;
        chk("bb_words", bb_n, 32'd13);
        chk("bb_no_bubble", bb_last - bb_first + 1, bb_n);

        // 6-word TLP with out_ready toggling every cycle
        tog_en = 1;
        send_tlp(6, 16'hC000);
        drain();
        tog_en = 0;
        #2;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("seq_after_stall", {20'b0, seq_num}, 32'(exp_seq));

        // Stray non-sop word in IDLE is dropped and latches err
        in_data = 16'hDEAD; in_sop = 1'b0; in_eop = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("drop_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("drop_err", {31'b0, err}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("drop_no_out", {31'b0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send_tlp(2, 16'h7000);
        drain();
        chk("err_sticky", {31'b0, err}, 32'd1);

        // Reset after word 3 of a 5-word TLP
        start_tlp();
        send_word(16'h5A01, 1'b1, 1'b0);
        send_word(16'h5A02, 1'b0, 1'b0);
        send_word(16'h5A03, 1'b0, 1'b0);
        do_reset();
        send_tlp(5, 16'h6100);
        drain();
        chk("post_abort_seq", {20'b0, seq_num}, 32'd1);
        chk("post_abort_err", {31'b0, err}, 32'd0);

        // sop on a later word is payload but flags err
        start_tlp();
        send_word(16'h9001, 1'b1, 1'b0);
        send_word(16'h9002, 1'b1, 1'b0);
        send_word(16'h9003, 1'b0, 1'b1);
        drain();
        chk("mid_sop_err", {31'b0, err}, 32'd1);

        // Sequence number wrap
        do_reset();
        for (int t = 0; t < 4095; t++)
            send_tlp(1, 16'(t));
        drain();
        chk("seq_preload", {20'b0, seq_num}, 32'd4095);
        send_tlp(1, 16'hBEEF);
        drain();
        chk("seq_wrap", {20'b0, seq_num}, 32'd0);
        send_tlp(1, 16'hCAFE);
        drain();
        chk("seq_after_wrap", {20'b0, seq_num}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
